// File: rtl/vmem_pkg.sv
// -----------------------------------------------------------------------------
// vmem_pkg
// Shared constants and types for the video memory arbiter slice.
//   VMEM_ADDR_W / VMEM_DATA_W : geometry of the 16384 x 12 video memory
//   VMEM_PALETTE_BASE         : first word of the palette region
//   VMEM_MODE_ADDR            : word address of the video mode-select register
//   vmem_state_e              : CPU-port arbitration FSM states
// -----------------------------------------------------------------------------
package vmem_pkg;

  localparam int VMEM_ADDR_W = 14;
  localparam int VMEM_DATA_W = 12;

  localparam logic [VMEM_ADDR_W-1:0] VMEM_PALETTE_BASE = 14'o30000;
  localparam logic [VMEM_ADDR_W-1:0] VMEM_MODE_ADDR    = 14'o30100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // waiting for a CPU request
    PEND    = 2'd1,  // request held, waiting for a cycle the video port leaves free
    ACK     = 2'd2,  // access done, completion pulse on cpu_ack
    RELEASE = 2'd3   // waiting for the CPU to drop cpu_req
  } vmem_state_e;

endpackage

// File: rtl/vmem_storage.sv
// -----------------------------------------------------------------------------
// vmem_storage
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// Read data is registered. A write cycle returns the old contents of the
// addressed word on q (read-before-write).
//   address : word address
//   clock   : rising-edge clock
//   data    : write data
//   wren    : write enable
//   q       : registered read data
// -----------------------------------------------------------------------------
module vmem_storage
  import vmem_pkg::*;
#(
  parameter int ADDR_W = VMEM_ADDR_W,
  parameter int DATA_W = VMEM_DATA_W
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              clock,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // NOTE: the array and its output register carry no reset; a reset would
  // stop this mapping onto a block RAM, and nothing relies on q after reset
  // because the arbiter only looks at q in a cycle after a real access.
  always_ff @(posedge clock) begin
    q <= r_mem[address];
    if (wren) begin
      r_mem[address] <= data;
    end
  end

endmodule

// File: rtl/video_memory_arbiter.sv
// -----------------------------------------------------------------------------
// video_memory_arbiter
// Shares one single-port video memory between the video generator (read only,
// absolute priority, one-cycle latency) and a CPU read/write port using a
// req/ack handshake. The CPU is served only in cycles where video_req is low.
//   clock      : system clock, rising edge
//   rst        : asynchronous reset, active low
//   video_req  : video generator owns the array this cycle
//   video_addr : video read address
//   video_data : read data for the previous cycle's video access, held otherwise
//   cpu_req    : CPU request, held with stable fields until cpu_ack
//   cpu_we     : 1 = write, 0 = read
//   cpu_addr   : CPU word address
//   cpu_wdata  : CPU write data
//   cpu_ack    : one-cycle completion pulse
//   cpu_rdata  : CPU read result, valid with cpu_ack, held until the next read
// -----------------------------------------------------------------------------
module video_memory_arbiter
  import vmem_pkg::*;
#(
  parameter int ADDR_W = VMEM_ADDR_W,
  parameter int DATA_W = VMEM_DATA_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              video_req,
  input  logic [ADDR_W-1:0] video_addr,
  output logic [DATA_W-1:0] video_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata
);

  vmem_state_e       r_state;
  vmem_state_e       w_next_state;

  // CPU request captured in IDLE so the access does not depend on the bus
  // keeping its fields stable while the video port starves us.
  logic              r_hold_we;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_wdata;

  // Which requester the RAM output belongs to in the current cycle.
  logic              r_video_served;
  logic              r_cpu_read_served;

  // Last values handed out, shown whenever q belongs to someone else.
  logic [DATA_W-1:0] r_video_data;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic              w_capture;
  logic              w_cpu_access;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_wren;
  logic [DATA_W-1:0] w_ram_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational; without it any path that skips an assignment infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (cpu_req)    w_next_state = PEND;
      PEND:    if (!video_req) w_next_state = ACK;
      ACK:                     w_next_state = RELEASE;
      RELEASE: if (!cpu_req)   w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and array port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    w_capture    = (r_state == IDLE) && cpu_req;
    w_cpu_access = (r_state == PEND) && !video_req;
    cpu_ack      = (r_state == ACK);

    // Video always wins the port; the held CPU access only gets it in PEND
    // when video is idle, so the two can never touch the array in one cycle.
    w_ram_addr = '0;
    w_ram_wren = 1'b0;
    if (video_req) begin
      w_ram_addr = video_addr;
    end else if (r_state == PEND) begin
      w_ram_addr = r_hold_addr;
      w_ram_wren = r_hold_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
    end else if (w_capture) begin
      r_hold_we    <= cpu_we;
      r_hold_addr  <= cpu_addr;
      r_hold_wdata <= cpu_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data steering
  // ---------------------------------------------------------------------------
  // The RAM output register already gives the one-cycle latency, so q is
  // passed straight out in the cycle after an access and copied into a hold
  // register at the end of that cycle; any later access (or an idle read) then
  // cannot disturb what the other requester sees.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_video_served    <= 1'b0;
      r_cpu_read_served <= 1'b0;
      r_video_data      <= '0;
      r_cpu_rdata       <= '0;
    end else begin
      r_video_served    <= video_req;
      r_cpu_read_served <= w_cpu_access && !r_hold_we;
      if (r_video_served) begin
        r_video_data <= w_ram_q;
      end
      if (r_cpu_read_served) begin
        r_cpu_rdata <= w_ram_q;
      end
    end
  end

  assign video_data = r_video_served    ? w_ram_q : r_video_data;
  assign cpu_rdata  = r_cpu_read_served ? w_ram_q : r_cpu_rdata;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  vmem_storage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_storage (
    .address (w_ram_addr),
    .clock   (clock),
    .data    (r_hold_wdata),
    .wren    (w_ram_wren),
    .q       (w_ram_q)
  );

endmodule

// File: tb/tb_video_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_video_memory_arbiter
// Directed self-checking bench for video_memory_arbiter. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_video_memory_arbiter;

  localparam int AW = 14;
  localparam int DW = 12;

  logic          clock;
  logic          rst;
  logic          video_req;
  logic [AW-1:0] video_addr;
  logic [DW-1:0] video_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  int n_asserts = 0;
  int n_fail    = 0;

  video_memory_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .video_req  (video_req),
    .video_addr (video_addr),
    .video_data (video_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full CPU transaction with video idle. Returns edges from request to ack
  // (-1 if no ack within the budget) and the read data seen with the ack.
  // Leaves the FSM back in IDLE.
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd,
                            output int lat, output logic [DW-1:0] rd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    lat = -1;
    rd  = '0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (cpu_ack) begin
        lat = n;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int            lat;
    int            n_acks;
    logic [DW-1:0] rd;

    rst        = 1'b0;
    video_req  = 1'b0;
    video_addr = '0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;

    // ---- reset state
    tick();
    tick();
    check("reset_video_data", 32'(video_data), 32'h0);
    check("reset_cpu_ack",    32'(cpu_ack),    32'h0);
    check("reset_cpu_rdata",  32'(cpu_rdata),  32'h0);
    rst = 1'b1;
    tick();

    // ---- preload through the CPU port: addr i = i, plus two marker words
    for (int i = 0; i < 8; i++) begin
      cpu_access(1'b1, AW'(i), DW'(i), lat, rd);
      check("preload_lat", 32'(lat), 32'd2);
    end
    cpu_access(1'b1, 14'h0100, 12'h111, lat, rd);
    check("preload_lat", 32'(lat), 32'd2);
    cpu_access(1'b1, 14'h0200, 12'h222, lat, rd);
    check("preload_lat", 32'(lat), 32'd2);

    // ---- back-to-back video stream 0..7
    video_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      video_addr = AW'(i);
      tick();
      check("video_stream", 32'(video_data), 32'(i));
    end
    video_req = 1'b0;
    tick();
    check("video_hold", 32'(video_data), 32'h7);
    tick();
    check("video_hold", 32'(video_data), 32'h7);

    // ---- CPU write then video read
    cpu_access(1'b1, 14'h1234, 12'hABC, lat, rd);
    check("cpu_write_lat", 32'(lat), 32'd2);
    check("video_after_cpu", 32'(video_data), 32'h7);
    video_req  = 1'b1;
    video_addr = 14'h1234;
    tick();
    video_req = 1'b0;
    check("video_read_new", 32'(video_data), 32'hABC);

    // ---- starved CPU read of 14'h0005 under 10 cycles of video
    video_req = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 14'h0005;
    for (int c = 0; c < 10; c++) begin
      video_addr = AW'(c % 8);
      tick();
      check("starve_no_ack", 32'(cpu_ack), 32'h0);
      check("starve_video", 32'(video_data), 32'(c % 8));
    end
    video_req = 1'b0;
    tick();
    check("starve_ack", 32'(cpu_ack), 32'h1);
    check("starve_rdata", 32'(cpu_rdata), 32'h005);
    check("starve_video_held", 32'(video_data), 32'h1);
    cpu_req = 1'b0;
    tick();
    check("starve_ack_pulse", 32'(cpu_ack), 32'h0);
    check("starve_rdata_held", 32'(cpu_rdata), 32'h005);
    tick();

    // ---- simultaneous video read and CPU write to the same word
    video_req  = 1'b1;
    video_addr = 14'h0100;
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 14'h0100;
    cpu_wdata  = 12'h5A5;
    tick();
    check("simul_video_old", 32'(video_data), 32'h111);
    check("simul_no_ack", 32'(cpu_ack), 32'h0);
    video_req = 1'b0;
    tick();
    check("simul_ack", 32'(cpu_ack), 32'h1);
    check("simul_video_held", 32'(video_data), 32'h111);
    check("simul_rdata_kept", 32'(cpu_rdata), 32'h005);
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    video_req = 1'b1;
    tick();
    check("simul_video_new", 32'(video_data), 32'h5A5);
    check("simul_ack_pulse", 32'(cpu_ack), 32'h0);
    video_req = 1'b0;
    tick();

    // ---- handshake hold: cpu_req high for 5 cycles after ack
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'h0002;
    tick();
    check("hs_pend_no_ack", 32'(cpu_ack), 32'h0);
    tick();
    check("hs_ack", 32'(cpu_ack), 32'h1);
    check("hs_rdata", 32'(cpu_rdata), 32'h002);
    cpu_addr = 14'h0003;
    n_acks = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cpu_ack) n_acks++;
    end
    check("hs_single_ack", 32'(n_acks), 32'd0);
    check("hs_rdata_held", 32'(cpu_rdata), 32'h002);
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick();
    tick();
    check("hs_second_ack", 32'(cpu_ack), 32'h1);
    check("hs_second_rdata", 32'(cpu_rdata), 32'h003);
    cpu_req = 1'b0;
    tick();
    tick();

    // ---- reset while a write is pending under video
    video_req  = 1'b1;
    video_addr = 14'h0007;
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 14'h0200;
    cpu_wdata  = 12'hFFF;
    tick();
    tick();
    check("rstp_pending_no_ack", 32'(cpu_ack), 32'h0);
    check("rstp_video_before", 32'(video_data), 32'h7);
    rst = 1'b0;
    #1;
    check("rstp_video_data", 32'(video_data), 32'h0);
    check("rstp_cpu_ack", 32'(cpu_ack), 32'h0);
    check("rstp_cpu_rdata", 32'(cpu_rdata), 32'h0);
    video_req = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    tick();
    rst = 1'b1;
    n_acks = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (cpu_ack) n_acks++;
    end
    check("rstp_never_ack", 32'(n_acks), 32'd0);
    video_req  = 1'b1;
    video_addr = 14'h0200;
    tick();
    video_req = 1'b0;
    check("rstp_word_unchanged", 32'(video_data), 32'h222);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
